mem_responder: RTL and testbench

- Memory-side responder for the NPC fetch and load/store path: it returns `inst` for a given `pc` and completes load/store accesses.
- Accepts one word request at a time over a valid/ready handshake. Holds a word-addressed internal array. Returns read data or a write acknowledgement after a fixed, programmable latency.
- Sits between the ifu/lsu request side and the storage. Replaces the direct combinational inst input and allows multi-cycle memory timing.

---
 rtl/mem_responder.sv | 171 +++++++++++++++++
 tb/tb_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory that answers one request at a time
// over valid/ready handshakes, after a fixed programmable latency.
// Reads return array data. Writes apply a byte-enable mask and return a
// zero-data acknowledgement. Misaligned or out-of-range accesses report
// resp_err and leave the array untouched.
module mem_responder #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h80000000,
    parameter int unsigned           LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err
);

    localparam int unsigned BYTES    = DATA_WIDTH / 8;
    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic        ZERO_LAT = (LATENCY == 0);
    // The WAIT countdown starts at LATENCY-1, so WAIT lasts LATENCY cycles.
    localparam logic [3:0]  LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state;
    logic [3:0]              count;

    // Request fields captured at accept time. After accept the requester's
    // inputs are no longer sampled.
    logic                    lat_wen;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [BYTES-1:0]        lat_wmask;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Fields of the access about to be performed. With zero latency the
    // access happens on the accept edge itself, so it must use the live
    // request inputs rather than the captured copy.
    logic                    acc_wen;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic [BYTES-1:0]        acc_wmask;

    logic [ADDR_WIDTH-1:0]   offset;
    logic [DEPTH_LOG2-1:0]   acc_index;
    logic [1:0]              addr_low;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    fault;
    logic                    accept;
    logic                    enter_resp;
    logic                    mem_we;

    assign accept = (state == IDLE) && req_valid && req_ready;

    // Pick the live request in IDLE (zero-latency case) or the captured one.
    always_comb begin
        acc_wen   = lat_wen;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_wmask = lat_wmask;
        if (state == IDLE) begin
            acc_wen   = req_wen;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wmask = req_wmask;
        end
    end

    // Offset wraps modulo 2^ADDR_WIDTH, so addresses below the base become
    // huge offsets and fall into the out-of-range check. The low address
    // bits are rebuilt from the offset so the whole offset word is used.
    assign offset       = acc_addr - BASE_ADDR;
    assign acc_index    = offset[DEPTH_LOG2+1:2];
    assign addr_low     = offset[1:0] + BASE_ADDR[1:0];
    assign misaligned   = (addr_low != 2'b00);
    assign out_of_range = |offset[ADDR_WIDTH-1:DEPTH_LOG2+2];
    assign fault        = misaligned || out_of_range;

    // The access is performed on the edge that moves the FSM into RESP.
    assign enter_resp = ((state == WAIT) && (count == 4'd0)) || (ZERO_LAT && accept);

    // A write commits only on that edge and never while reset is asserted,
    // so a transaction aborted by reset leaves the array untouched.
    assign mem_we = rst && enter_resp && acc_wen && !fault;

    // Byte-masked array write; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (acc_wmask[i]) begin
                    mem[acc_index][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Handshake FSM with registered outputs; entering RESP overrides the
    // per-state updates so the zero-latency path goes straight to RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= 4'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_wen    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        lat_wen   <= req_wen;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_wmask <= req_wmask;
                        count     <= LAT_INIT;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    // A new request is not accepted on this edge because
                    // req_ready only rises here.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (enter_resp) begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_err   <= fault;
                resp_rdata <= (fault || acc_wen) ? '0 : mem[acc_index];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and randomized checks of mem_responder.
// Two instances are exercised: LATENCY=2 (index 0) and LATENCY=0 (index 1).
// Expected data comes from a byte-level sparse memory model per instance.
module tb_mem_responder;

    localparam logic [31:0] BASE     = 32'h80000000;
    localparam int          LAT_MAIN = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_wen    [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_wmask  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int passCount  = 0;
    int checkCount = 0;

    // Sparse reference memories: word data plus which bytes are known.
    logic [31:0] modelData0  [int];
    logic [31:0] modelData1  [int];
    logic [3:0]  modelKnown0 [int];
    logic [3:0]  modelKnown1 [int];

    int poolIdx [8] = '{0, 4, 8, 9, 100, 1000, 2047, 4095};

    mem_responder #(.LATENCY(LAT_MAIN)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_wen    (req_wen[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .req_wmask  (req_wmask[0]),
        .resp_valid (resp_valid[0]),
        .resp_ready (resp_ready[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0])
    );

    mem_responder #(.LATENCY(0)) dut_zero (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_wen    (req_wen[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .req_wmask  (req_wmask[1]),
        .resp_valid (resp_valid[1]),
        .resp_ready (resp_ready[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1])
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Applies the memory rules to the model and returns the expected response.
    task automatic modelAccess(input int u, input logic wen, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] mask,
                               output logic [31:0] expData, output logic expErr,
                               output bit known);
        logic [31:0] off;
        logic [31:0] word;
        logic [3:0]  km;
        int          idx;
        off     = addr - BASE;
        expErr  = (addr % 4 != 0) || (off >= 32'h4000);
        expData = 32'h0;
        known   = 1'b1;
        if (expErr) return;
        idx  = int'(off / 4);
        word = 32'h0;
        km   = 4'h0;
        if (u == 0) begin
            if (modelData0.exists(idx)) begin
                word = modelData0[idx];
                km   = modelKnown0[idx];
            end
        end else begin
            if (modelData1.exists(idx)) begin
                word = modelData1[idx];
                km   = modelKnown1[idx];
            end
        end
        if (wen) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) begin
                    word[8*b +: 8] = wdata[8*b +: 8];
                    km[b]          = 1'b1;
                end
            end
            if (u == 0) begin
                modelData0[idx]  = word;
                modelKnown0[idx] = km;
            end else begin
                modelData1[idx]  = word;
                modelKnown1[idx] = km;
            end
        end else begin
            expData = word;
            known   = (km == 4'hF);
        end
    endtask

    // One full transaction on instance u, entered and left at a negedge.
    // Checks latency, response fields, stability under backpressure and
    // the return of req_ready after the response handshake.
    task automatic applyStimulus(input string tag, input int u, input logic wen,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] mask, input int stall);
        logic [31:0] expData;
        logic        expErr;
        bit          known;
        int          waitCount;
        int          lat;
        modelAccess(u, wen, addr, wdata, mask, expData, expErr, known);
        waitCount = 0;
        while (!req_ready[u] && waitCount < 50) begin
            @(negedge clk);
            waitCount++;
        end
        if (!req_ready[u]) begin
            checkOutput({tag, ".readyTimeout"}, 32'(req_ready[u]), 32'd1);
            return;
        end
        req_wen[u]   = wen;
        req_addr[u]  = addr;
        req_wdata[u] = wdata;
        req_wmask[u] = mask;
        req_valid[u] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[u] = 1'b0;
        req_wdata[u] = $urandom;
        @(negedge clk);
        checkOutput({tag, ".readyLowAfterAccept"}, 32'(req_ready[u]), 32'd0);
        lat = 1;
        while (!resp_valid[u] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, ".latency"}, lat, (u == 0) ? LAT_MAIN + 1 : 1);
        if (!resp_valid[u]) return;
        checkOutput({tag, ".err"}, 32'(resp_err[u]), 32'(expErr));
        if (known) checkOutput({tag, ".rdata"}, resp_rdata[u], expData);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput({tag, ".stallValid"}, 32'(resp_valid[u]), 32'd1);
            checkOutput({tag, ".stallReady"}, 32'(req_ready[u]), 32'd0);
            checkOutput({tag, ".stallErr"}, 32'(resp_err[u]), 32'(expErr));
            if (known) checkOutput({tag, ".stallRdata"}, resp_rdata[u], expData);
        end
        resp_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[u] = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".readyAfterResp"}, 32'(req_ready[u]), 32'd1);
        checkOutput({tag, ".validCleared"}, 32'(resp_valid[u]), 32'd0);
        checkOutput({tag, ".rdataCleared"}, resp_rdata[u], 32'h0);
        checkOutput({tag, ".errCleared"}, 32'(resp_err[u]), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag, input int u);
        checkOutput({tag, ".reqReady"}, 32'(req_ready[u]), 32'd0);
        checkOutput({tag, ".respValid"}, 32'(resp_valid[u]), 32'd0);
        checkOutput({tag, ".rdata"}, resp_rdata[u], 32'h0);
        checkOutput({tag, ".err"}, 32'(resp_err[u]), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          u;
        int          k;
        int          sel;
        logic        wen;
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            req_valid[i]  = 1'b0;
            req_wen[i]    = 1'b0;
            req_addr[i]   = 32'h0;
            req_wdata[i]  = 32'h0;
            req_wmask[i]  = 4'h0;
            resp_ready[i] = 1'b0;
        end

        $display("[TB] reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset0", 0);
        checkResetOutputs("reset1", 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("readyAfterRelease0", 32'(req_ready[0]), 32'd1);
        checkOutput("readyAfterRelease1", 32'(req_ready[1]), 32'd1);

        $display("[TB] first read and basic write/read");
        applyStimulus("firstRead", 0, 1'b0, 32'h80000000, 32'h0, 4'h0, 0);
        applyStimulus("word0Write", 0, 1'b1, 32'h80000000, 32'hCAFEF00D, 4'hF, 0);
        applyStimulus("beefWrite", 0, 1'b1, 32'h80000010, 32'hDEADBEEF, 4'hF, 0);
        applyStimulus("beefRead", 0, 1'b0, 32'h80000010, 32'h0, 4'h0, 0);

        $display("[TB] byte mask");
        applyStimulus("maskFull", 0, 1'b1, 32'h80000020, 32'h11223344, 4'hF, 0);
        applyStimulus("maskPart", 0, 1'b1, 32'h80000020, 32'hAABBCCDD, 4'b0101, 0);
        applyStimulus("maskRead", 0, 1'b0, 32'h80000020, 32'h0, 4'h0, 0);
        checkOutput("maskModel", modelData0[8], 32'h11BB33DD);

        $display("[TB] faults");
        applyStimulus("pastEnd", 0, 1'b0, 32'h80004000, 32'h0, 4'h0, 0);
        applyStimulus("misaligned", 0, 1'b0, 32'h80000002, 32'h0, 4'h0, 0);
        applyStimulus("underflow", 0, 1'b0, 32'h7FFFFFFC, 32'h0, 4'h0, 0);
        applyStimulus("pastEndWrite", 0, 1'b1, 32'h80004000, 32'h55555555, 4'hF, 0);
        applyStimulus("word0Intact", 0, 1'b0, 32'h80000000, 32'h0, 4'h0, 0);
        applyStimulus("beefIntact", 0, 1'b0, 32'h80000010, 32'h0, 4'h0, 0);

        $display("[TB] backpressure");
        applyStimulus("stall5", 0, 1'b0, 32'h80000010, 32'h0, 4'h0, 5);

        $display("[TB] reset abort");
        req_wen[0]   = 1'b1;
        req_addr[0]  = 32'h80000010;
        req_wdata[0] = 32'h12345678;
        req_wmask[0] = 4'hF;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkResetOutputs("abortReset", 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abortReady", 32'(req_ready[0]), 32'd1);
        applyStimulus("abortRead", 0, 1'b0, 32'h80000010, 32'h0, 4'h0, 0);

        $display("[TB] zero latency");
        applyStimulus("z.write", 1, 1'b1, 32'h80000040, 32'h0BADF00D, 4'hF, 0);
        applyStimulus("z.read", 1, 1'b0, 32'h80000040, 32'h0, 4'h0, 1);
        applyStimulus("z.fault", 1, 1'b0, 32'h80000041, 32'h0, 4'h0, 0);

        $display("[TB] randomized traffic");
        for (int uu = 0; uu < 2; uu++) begin
            for (int p = 0; p < 8; p++) begin
                applyStimulus("poolInit", uu, 1'b1, BASE + 32'(4 * poolIdx[p]),
                              $urandom, 4'hF, 0);
            end
        end
        for (int n = 0; n < 60; n++) begin
            u   = (n < 40) ? 0 : 1;
            k   = $urandom_range(0, 7);
            sel = $urandom_range(0, 9);
            a   = BASE + 32'(4 * poolIdx[k]);
            wen = 1'($urandom_range(0, 1));
            case (sel)
                6: a = a + 32'($urandom_range(1, 3));
                7: a = a + 32'h4000;
                8: a = BASE - 32'(4 * $urandom_range(1, 4));
                9: wen = 1'b0;
                default: ;
            endcase
            applyStimulus("rand", u, wen, a, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 2));
        end
        for (int uu = 0; uu < 2; uu++) begin
            for (int p = 0; p < 8; p++) begin
                applyStimulus("poolFinal", uu, 1'b0, BASE + 32'(4 * poolIdx[p]),
                              32'h0, 4'h0, 0);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
